// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder definitions.
// Holds the block geometry and the read-scheduler state encoding used by
// block_read_sched.
package jpeg_enc_pkg;

    localparam int BLOCK_SIZE = 8;
    localparam int BLOCK_PX   = BLOCK_SIZE * BLOCK_SIZE;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle.
// Parameters: DATA_W (TDATA width, whole bytes), ID_W, DEST_W.
// Modports: master drives payload and tvalid, slave drives tready.
interface axi4_stream_if #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic                  tuser;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface

// File: rtl/block_read_sched.sv
// block_read_sched: drains the per-line FIFOs of the line buffer in 8x8
// block order and merges them into one block-serial pixel stream.
//
// Ports:
//   clk_i    - clock
//   rst_n_i  - asynchronous active-low reset
//   lines_i  - BUF_AMOUNT line FIFO outputs (AXI4-Stream slaves)
//   block_o  - block-serial pixel stream (AXI4-Stream master), 1 register stage
//   band_o   - band currently being drained
//   err_o    - sticky line-length error
//
// Optional feature: define BLOCK_READ_SCHED_LINE_CHECK_EN to build the
// input tlast position check driving err_o; otherwise err_o is 0.
module block_read_sched
    import jpeg_enc_pkg::*;
#(
    parameter int BUF_AMOUNT  = 16,
    parameter int PX_WIDTH    = 8,
    parameter int FRAME_RES_X = 1280,
    localparam int NUM_BANDS  = BUF_AMOUNT / BLOCK_SIZE,
    localparam int BAND_W     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    axi4_stream_if.slave      lines_i [BUF_AMOUNT],
    axi4_stream_if.master     block_o,
    output logic [BAND_W-1:0] band_o,
    output logic              err_o
);

    localparam int TDATA_W = ((PX_WIDTH + 7) / 8) * 8;
    localparam int KEEP_W  = TDATA_W / 8;
    localparam int NUM_BLK = FRAME_RES_X / BLOCK_SIZE;
    localparam int BLK_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam int IDX_W   = $clog2(BLOCK_SIZE);
    localparam int SEL_W   = (BUF_AMOUNT > 1) ? $clog2(BUF_AMOUNT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NUM_BLK - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);

    // Interface array unpacked into packed vectors so the source mux can
    // use a run-time index.
    logic [BUF_AMOUNT-1:0]              vld_v;
    logic [BUF_AMOUNT-1:0]              usr_v;
    logic [BUF_AMOUNT-1:0]              rdy_v;
    logic [BUF_AMOUNT-1:0][TDATA_W-1:0] dat_v;
    logic [BUF_AMOUNT-1:0][KEEP_W-1:0]  strb_v;
    logic [BUF_AMOUNT-1:0][KEEP_W-1:0]  keep_v;

    for (genvar g = 0; g < BUF_AMOUNT; g++) begin : g_line
        assign vld_v[g]  = lines_i[g].tvalid;
        assign usr_v[g]  = lines_i[g].tuser;
        assign dat_v[g]  = lines_i[g].tdata;
        assign strb_v[g] = lines_i[g].tstrb;
        assign keep_v[g] = lines_i[g].tkeep;
        assign lines_i[g].tready = rdy_v[g];
    end

    sched_state_t       state;
    logic [IDX_W-1:0]   col, row;
    logic [BLK_W-1:0]   blk;
    logic [BAND_W-1:0]  band;

    logic               out_vld, out_lst, out_usr;
    logic [TDATA_W-1:0] out_dat;
    logic [KEEP_W-1:0]  out_strb, out_keep;

    logic [SEL_W-1:0]   sel;
    logic               in_vld, in_usr, load, accept, first_pos, bad_sof, fwd;

    // Counters are zeroed on entry to FLUSH, so sel is line 0 there too.
    assign sel       = SEL_W'(int'(band) * BLOCK_SIZE) + SEL_W'(row);
    assign in_vld    = vld_v[sel];
    assign in_usr    = usr_v[sel];
    assign load      = !out_vld || block_o.tready;
    assign first_pos = (col == '0) && (row == '0) && (blk == '0);

    always_comb begin
        rdy_v = '0;
        if (state == FLUSH)
            // Junk ahead of the frame start is dropped at full rate; the
            // start-of-frame beat itself waits for room in the output stage.
            rdy_v[0] = usr_v[0] ? load : 1'b1;
        else
            rdy_v[sel] = load;
    end

    assign accept  = in_vld && rdy_v[sel];
    assign bad_sof = (state == RUN) && accept && in_usr && !first_pos;
    assign fwd     = accept && ((state == RUN) ? !bad_sof : in_usr);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= RUN;
            col      <= '0;
            row      <= '0;
            blk      <= '0;
            band     <= '0;
            out_vld  <= 1'b0;
            out_lst  <= 1'b0;
            out_usr  <= 1'b0;
            out_dat  <= '0;
            out_strb <= '0;
            out_keep <= '0;
        end else begin
            if (load) begin
                out_vld <= fwd;
                if (fwd) begin
                    out_dat  <= dat_v[sel];
                    out_strb <= strb_v[sel];
                    out_keep <= keep_v[sel];
                    out_usr  <= in_usr;
                    out_lst  <= (row == IDX_LAST) && (col == IDX_LAST);
                end
            end

            if (bad_sof) begin
                // Misplaced frame start: drop it and resync on line 0.
                state <= FLUSH;
                col   <= '0;
                row   <= '0;
                blk   <= '0;
                band  <= '0;
            end else if (fwd) begin
                state <= RUN;
                if (col == IDX_LAST) begin
                    col <= '0;
                    if (row == IDX_LAST) begin
                        row <= '0;
                        if (blk == BLK_LAST) begin
                            blk  <= '0;
                            band <= (band == BAND_LAST) ? '0 : band + 1'b1;
                        end else begin
                            blk <= blk + 1'b1;
                        end
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign block_o.tvalid = out_vld;
    assign block_o.tdata  = out_dat;
    assign block_o.tstrb  = out_strb;
    assign block_o.tkeep  = out_keep;
    assign block_o.tlast  = out_lst;
    assign block_o.tuser  = out_usr;
    assign block_o.tid    = '0;
    assign block_o.tdest  = '0;
    assign band_o         = band;

`ifdef BLOCK_READ_SCHED_LINE_CHECK_EN
    logic [BUF_AMOUNT-1:0] lst_v;
    logic                  err_q;

    for (genvar g = 0; g < BUF_AMOUNT; g++) begin : g_lst
        assign lst_v[g] = lines_i[g].tlast;
    end

    // tlast must coincide exactly with the last pixel of the line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            err_q <= 1'b0;
        else if (accept && (state == RUN) &&
                 (lst_v[sel] != ((blk == BLK_LAST) && (col == IDX_LAST))))
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
